autoseller_arbiter: RTL and testbench
=====================================

// Module: autoseller_arbiter
// PURPOSE
//  Shares one autoseller vending core between NUM_REQ customer ports.
//  Arbitrates round-robin and issues one transaction at a time to the seller.
//  Waits for the seller's result with a watchdog, then routes change/drink
//  back to the granted requester. Sits between the front-panel ports and
//  the autoseller instance.
// PARAMETERS
//  NUM_REQ  4   number of requester ports (2..8)
//  TIMEOUT  32  cycles in WAIT before a transaction is aborted (>=2)
// PORTS
//  clk           in   1          single clock, rising edge
//  reset_n       in   1          asynchronous, active-low reset
//  req_valid_i   in   NUM_REQ    per-port request; held high until req_ack_o
//  req_money_i   in   6*NUM_REQ  port k money at [6k+5:6k], hex coins
//  req_type_i    in   2*NUM_REQ  port k drink type at [2k+1:2k]
//  req_ack_o     out  NUM_REQ    one-cycle pulse: request k accepted
//  rsp_valid_o   out  1          one-cycle pulse: response on rsp_* is valid
//  rsp_id_o      out  3          port index owning the response
//  rsp_change_o  out  6          change returned
//  rsp_drink_o   out  2          drink delivered
//  rsp_err_o     out  1          1 = watchdog abort (refund)
//  sel_ready_i   in   1          seller ready_o
//  sel_enable_o  out  1          to seller enable_i, one-cycle pulse
//  sel_money_o   out  6          to seller money_i
//  sel_type_o    out  2          to seller drinktype_i
//  sel_done_i    in   1          seller enable_o
//  sel_change_i  in   6          seller change_o
//  sel_drink_i   in   2          seller drink_o
//  served_cnt_o  out  8          completed transactions, including aborts
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE, rr_ptr=0, served_cnt_o=0.
//   All other outputs are 0, and latched money/type/id are 0.
//  FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. Registered outputs only.
//  IDLE
//   - Arbitrate when sel_ready_i=1 and |req_valid_i.
//   - Grant g = first set bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
//   - At that edge, latch money[g], type[g] and g; go to ISSUE.
//   - If sel_ready_i=0, no grant is made and requests keep waiting.
//  ISSUE (exactly 1 cycle)
//   - sel_enable_o=1 and req_ack_o[g]=1.
//   - sel_money_o/sel_type_o carry the latched values.
//   - The watchdog is cleared. Go to WAIT.
//  WAIT
//   - sel_enable_o=0 and sel_money_o/sel_type_o=0.
//   - The watchdog increments each cycle.
//   - sel_done_i=1: latch sel_change_i/sel_drink_i, err=0, go to RESP.
//   - Watchdog reaches TIMEOUT-1 with no done: change=latched money,
//     drink=0, err=1, go to RESP.
//   - A done arriving on the timeout cycle wins (err=0).
//  RESP (exactly 1 cycle)
//   - rsp_valid_o=1, rsp_id_o=g, rsp_change_o/rsp_drink_o/rsp_err_o as latched.
//   - rr_ptr becomes (g+1) mod NUM_REQ.
//   - served_cnt_o increments by 1 and wraps 255->0.
//   - Go to IDLE.
//  rsp_* and sel_* data outputs are 0 outside their strobe cycles.
//  sel_done_i outside WAIT is ignored and produces no response.
//  req_valid_i changes outside IDLE are ignored. Requests are not queued:
//   a port that drops valid before its ack loses its request.
//  money=0 requests are forwarded unchanged; the seller decides the result.
//  Throughput: at most 1 transaction per 4 cycles, with an IDLE gap of >=1 cycle.
//  reset_n asserted mid-transaction aborts the transaction silently,
//   with no rsp_valid_o.
// TESTING
//  1. Port 1 only, money=0x14, type=01, seller done change=0x05 drink=01
//     -> req_ack_o=0010 in ISSUE; rsp id=1, change=5, drink=01, err=0.
//  2. All 4 ports valid continuously, 8 transactions -> ack order 0,1,2,3,0,1,2,3;
//     served_cnt_o=8.
//  3. sel_ready_i=0 for 10 cycles with port 2 valid -> no ack, no sel_enable_o;
//     grant on the first cycle after ready rises.
//  4. Seller never raises done, TIMEOUT=32, money=0x0A -> rsp err=1, change=0x0A,
//     drink=00; rsp_valid_o exactly 32 cycles after ISSUE.
//  5. reset_n low during WAIT -> all outputs 0 at once, no rsp_valid_o;
//     the next request after reset is granted to port 0 first.
//  6. Spurious sel_done_i in IDLE -> no rsp_valid_o; served_cnt_o unchanged.

Source files
------------

// File: rtl/autoseller_arbiter.sv
// Round-robin front end that shares one autoseller core between NUM_REQ ports.
// One transaction in flight at a time; a watchdog turns a silent seller into a refund.
module autoseller_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [6*NUM_REQ-1:0]   req_money_i,
  input  logic [2*NUM_REQ-1:0]   req_type_i,
  output logic [NUM_REQ-1:0]     req_ack_o,
  output logic                   rsp_valid_o,
  output logic [2:0]             rsp_id_o,
  output logic [5:0]             rsp_change_o,
  output logic [1:0]             rsp_drink_o,
  output logic                   rsp_err_o,
  input  logic                   sel_ready_i,
  output logic                   sel_enable_o,
  output logic [5:0]             sel_money_o,
  output logic [1:0]             sel_type_o,
  input  logic                   sel_done_i,
  input  logic [5:0]             sel_change_i,
  input  logic [1:0]             sel_drink_i,
  output logic [7:0]             served_cnt_o
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int WDW  = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e               state_q, state_d;
  logic [2:0]           rrPtr_q, rrPtr_d;
  logic [2:0]           id_q, id_d;
  logic [5:0]           money_q, money_d;
  logic [1:0]           type_q, type_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic [7:0]           served_q, served_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 selEn_q, selEn_d;
  logic [5:0]           selMoney_q, selMoney_d;
  logic [1:0]           selType_q, selType_d;
  logic                 rspValid_q, rspValid_d;
  logic [2:0]           rspId_q, rspId_d;
  logic [5:0]           rspChange_q, rspChange_d;
  logic [1:0]           rspDrink_q, rspDrink_d;
  logic                 rspErr_q, rspErr_d;

  logic                 found;
  logic [2:0]           grant;
  logic [3:0]           cand;

  // First valid port at or after the round-robin pointer, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rrPtr_q} + 4'(i);
      if (cand >= 4'(NUM_REQ)) cand = cand - 4'(NUM_REQ);
      if (!found && req_valid_i[cand[IDXW-1:0]]) begin
        found = 1'b1;
        grant = cand[2:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    rrPtr_d     = rrPtr_q;
    id_d        = id_q;
    money_d     = money_q;
    type_d      = type_q;
    wd_d        = wd_q;
    served_d    = served_q;
    ack_d       = '0;
    selEn_d     = 1'b0;
    selMoney_d  = '0;
    selType_d   = '0;
    rspValid_d  = 1'b0;
    rspId_d     = '0;
    rspChange_d = '0;
    rspDrink_d  = '0;
    rspErr_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel_ready_i && found) begin
          id_d       = grant;
          money_d    = 6'(req_money_i >> (6 * grant));
          type_d     = 2'(req_type_i >> (2 * grant));
          ack_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant;
          selEn_d    = 1'b1;
          selMoney_d = money_d;
          selType_d  = type_d;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the final watchdog cycle still counts as a real result.
        if (sel_done_i || wd_q == WDW'(TIMEOUT - 2)) begin
          rspValid_d  = 1'b1;
          rspId_d     = id_q;
          rspChange_d = sel_done_i ? sel_change_i : money_q;
          rspDrink_d  = sel_done_i ? sel_drink_i : 2'b00;
          rspErr_d    = ~sel_done_i;
          served_d    = served_q + 8'd1;
          rrPtr_d     = (id_q == 3'(NUM_REQ - 1)) ? 3'd0 : id_q + 3'd1;
          state_d     = RESP;
        end else begin
          wd_d = wd_q + WDW'(1);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rrPtr_q     <= '0;
      id_q        <= '0;
      money_q     <= '0;
      type_q      <= '0;
      wd_q        <= '0;
      served_q    <= '0;
      ack_q       <= '0;
      selEn_q     <= 1'b0;
      selMoney_q  <= '0;
      selType_q   <= '0;
      rspValid_q  <= 1'b0;
      rspId_q     <= '0;
      rspChange_q <= '0;
      rspDrink_q  <= '0;
      rspErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rrPtr_q     <= rrPtr_d;
      id_q        <= id_d;
      money_q     <= money_d;
      type_q      <= type_d;
      wd_q        <= wd_d;
      served_q    <= served_d;
      ack_q       <= ack_d;
      selEn_q     <= selEn_d;
      selMoney_q  <= selMoney_d;
      selType_q   <= selType_d;
      rspValid_q  <= rspValid_d;
      rspId_q     <= rspId_d;
      rspChange_q <= rspChange_d;
      rspDrink_q  <= rspDrink_d;
      rspErr_q    <= rspErr_d;
    end
  end

  assign req_ack_o    = ack_q;
  assign sel_enable_o = selEn_q;
  assign sel_money_o  = selMoney_q;
  assign sel_type_o   = selType_q;
  assign rsp_valid_o  = rspValid_q;
  assign rsp_id_o     = rspId_q;
  assign rsp_change_o = rspChange_q;
  assign rsp_drink_o  = rspDrink_q;
  assign rsp_err_o    = rspErr_q;
  assign served_cnt_o = served_q;

endmodule

// File: tb/tb_autoseller_arbiter.sv
// Scoreboard bench for autoseller_arbiter: a behavioural seller answers each
// issue, and expected grants/responses are queued as stimulus is applied.
module tb_autoseller_arbiter;

  localparam int NUM_REQ = 4;
  localparam int TIMEOUT = 32;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [3:0]   req_valid_i = '0;
  logic [23:0]  req_money_i = '0;
  logic [7:0]   req_type_i = '0;
  logic [3:0]   req_ack_o;
  logic         rsp_valid_o;
  logic [2:0]   rsp_id_o;
  logic [5:0]   rsp_change_o;
  logic [1:0]   rsp_drink_o;
  logic         rsp_err_o;
  logic         sel_ready_i = 1'b1;
  logic         sel_enable_o;
  logic [5:0]   sel_money_o;
  logic [1:0]   sel_type_o;
  logic         sel_done_i = 1'b0;
  logic [5:0]   sel_change_i = '0;
  logic [1:0]   sel_drink_i = '0;
  logic [7:0]   served_cnt_o;

  autoseller_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid_i(req_valid_i), .req_money_i(req_money_i), .req_type_i(req_type_i),
    .req_ack_o(req_ack_o), .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o),
    .rsp_change_o(rsp_change_o), .rsp_drink_o(rsp_drink_o), .rsp_err_o(rsp_err_o),
    .sel_ready_i(sel_ready_i), .sel_enable_o(sel_enable_o), .sel_money_o(sel_money_o),
    .sel_type_o(sel_type_o), .sel_done_i(sel_done_i), .sel_change_i(sel_change_i),
    .sel_drink_i(sel_drink_i), .served_cnt_o(served_cnt_o)
  );

  typedef struct {
    logic [3:0] ack;
    logic [2:0] id;
    logic [5:0] money;
    logic [1:0] typ;
    logic [5:0] change;
    logic [1:0] drink;
    logic       err;
    int         lat;
  } exp_t;

  exp_t       expQ[$];
  int         vecCount = 0;
  int         errCount = 0;
  int         cycle = 0;
  int         issueCycle = 0;
  int         ackCount = 0;
  int         rspCount = 0;
  int         dropAfter = 0;
  int         expServed = 0;
  int         sellerLatency = 2;
  bit         sellerMute = 1'b0;
  logic [5:0] portMoney[4];
  logic [1:0] portType[4];

  initial forever #5 clk = ~clk;
  initial forever begin @(posedge clk); cycle++; end

  // The seller charges a fixed price of 0x0F when it can, else refunds.
  function automatic logic [5:0] sellerChange(input logic [5:0] money);
    return (money >= 6'h0F) ? money - 6'h0F : money;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vecCount++;
    if (obs !== expv) begin
      errCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input int port, input bit timeoutCase);
    exp_t e;
    e.ack   = 4'(1 << port);
    e.id    = 3'(port);
    e.money = portMoney[port];
    e.typ   = portType[port];
    if (timeoutCase) begin
      e.change = e.money; e.drink = 2'b00; e.err = 1'b1; e.lat = TIMEOUT;
    end else begin
      e.change = sellerChange(e.money); e.drink = e.typ; e.err = 1'b0; e.lat = sellerLatency + 2;
    end
    expQ.push_back(e);
    expServed++;
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int drops);
    @(posedge clk); #1;
    for (int k = 0; k < 4; k++) begin
      req_money_i[6*k +: 6] = portMoney[k];
      req_type_i[2*k +: 2]  = portType[k];
    end
    dropAfter   = drops;
    req_valid_i = mask;
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int n = 0; n < budget && expQ.size() != 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput({tag, "_drain"}, 32'(expQ.size()), 32'd0);
    checkOutput({tag, "_served"}, 32'(served_cnt_o), 32'(expServed & 255));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {req_ack_o, rsp_valid_o, rsp_id_o, rsp_change_o, rsp_drink_o, rsp_err_o,
                      sel_enable_o, sel_money_o, sel_type_o, served_cnt_o}, 32'd0);
  endtask

  // Behavioural seller: answers sellerLatency cycles after the enable strobe.
  initial begin
    bit pending = 1'b0;
    bit doneHigh = 1'b0;
    int cnt = 0;
    logic [5:0] capChange = '0;
    logic [1:0] capDrink = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) pending = 1'b0;
      if (doneHigh) begin sel_done_i = 1'b0; doneHigh = 1'b0; end
      if (pending) begin
        if (cnt == 0) begin
          sel_done_i = 1'b1; doneHigh = 1'b1;
          sel_change_i = capChange; sel_drink_i = capDrink;
          pending = 1'b0;
        end else cnt--;
      end
      if (reset_n && sel_enable_o && !sellerMute) begin
        pending = 1'b1; cnt = sellerLatency;
        capChange = sellerChange(sel_money_o); capDrink = sel_type_o;
      end
    end
  end

  // Monitor: compares issues and responses against the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (sel_enable_o) begin
          checkOutput("issue_pending", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0) begin
            checkOutput("ack", 32'(req_ack_o), 32'(expQ[0].ack));
            checkOutput("sel_money", 32'(sel_money_o), 32'(expQ[0].money));
            checkOutput("sel_type", 32'(sel_type_o), 32'(expQ[0].typ));
          end
          issueCycle = cycle;
        end else if (req_ack_o != 4'b0) begin
          checkOutput("ack_without_enable", 32'(req_ack_o), 32'd0);
        end
        if (req_ack_o != 4'b0) begin
          ackCount++;
          if (dropAfter > 0) begin
            dropAfter--;
            if (dropAfter == 0) req_valid_i = '0;
          end
        end
        if (rsp_valid_o) begin
          rspCount++;
          checkOutput("rsp_pending", 32'(expQ.size() != 0), 32'd1);
          if (expQ.size() != 0) begin
            e = expQ.pop_front();
            checkOutput("rsp_id", 32'(rsp_id_o), 32'(e.id));
            checkOutput("rsp_change", 32'(rsp_change_o), 32'(e.change));
            checkOutput("rsp_drink", 32'(rsp_drink_o), 32'(e.drink));
            checkOutput("rsp_err", 32'(rsp_err_o), 32'(e.err));
            checkOutput("rsp_latency", 32'(cycle - issueCycle), 32'(e.lat));
          end
        end
      end
    end
  end

  initial begin
    int a0;
    int r0;
    #12;
    checkAllZero("reset_outputs");
    @(negedge clk); reset_n = 1'b1;

    // All four ports held valid: strict rotation from port 0, zero money included.
    portMoney = '{6'h00, 6'h11, 6'h22, 6'h3F};
    portType  = '{2'd0, 2'd1, 2'd2, 2'd3};
    for (int t = 0; t < 8; t++) pushExp(t % 4, 1'b0);
    applyStimulus(4'b1111, 8);
    waitIdle("rr_all", 200);

    // Single request on port 1.
    portMoney[1] = 6'h14; portType[1] = 2'b01;
    pushExp(1, 1'b0);
    applyStimulus(4'b0010, 1);
    waitIdle("port1", 50);

    // Seller busy: port 2 must wait, then win on the first ready cycle.
    @(posedge clk); #1 sel_ready_i = 1'b0;
    portMoney[2] = 6'h2A; portType[2] = 2'b10;
    a0 = ackCount;
    applyStimulus(4'b0100, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("not_ready_no_ack", 32'(ackCount - a0), 32'd0);
    @(posedge clk); #1 sel_ready_i = 1'b1;
    pushExp(2, 1'b0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("grant_after_ready", 32'(sel_enable_o), 32'd1);
    waitIdle("ready", 50);

    // Pointer now at 3: ports 0 and 2 pending must go 0 then 2.
    portMoney[0] = 6'h30; portMoney[2] = 6'h0E;
    pushExp(0, 1'b0); pushExp(2, 1'b0);
    applyStimulus(4'b0101, 2);
    waitIdle("rr_wrap", 100);

    // Silent seller: watchdog refund 32 cycles after issue.
    sellerMute = 1'b1;
    portMoney[0] = 6'h0A; portType[0] = 2'b11;
    pushExp(0, 1'b1);
    applyStimulus(4'b0001, 1);
    waitIdle("timeout", 100);
    sellerMute = 1'b0;

    // Done arriving on the last watchdog cycle is a normal result.
    sellerLatency = TIMEOUT - 2;
    portMoney[3] = 6'h20; portType[3] = 2'b01;
    pushExp(3, 1'b0);
    applyStimulus(4'b1000, 1);
    waitIdle("done_at_limit", 100);
    sellerLatency = 2;

    // Stray done while idle produces nothing.
    r0 = rspCount;
    @(posedge clk); #1 sel_done_i = 1'b1; sel_change_i = 6'h3F; sel_drink_i = 2'b11;
    @(posedge clk); #1 sel_done_i = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("spurious_no_rsp", 32'(rspCount - r0), 32'd0);
    checkOutput("spurious_served", 32'(served_cnt_o), 32'(expServed & 255));

    // Reset mid-WAIT: silent abort, pointer back to 0.
    portMoney[1] = 6'h15; portType[1] = 2'b10;
    pushExp(1, 1'b0);
    applyStimulus(4'b0010, 1);
    waitIdle("pre_abort", 50);
    sellerMute = 1'b1;
    portMoney[2] = 6'h33;
    pushExp(2, 1'b1);
    a0 = ackCount; r0 = rspCount;
    applyStimulus(4'b0100, 1);
    repeat (6) @(posedge clk);
    @(negedge clk);
    checkOutput("abort_issued", 32'(ackCount - a0), 32'd1);
    reset_n = 1'b0;
    #1;
    checkAllZero("abort_outputs");
    expQ.delete();
    expServed = 0; sellerMute = 1'b0; req_valid_i = '0; dropAfter = 0;
    repeat (3) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    checkOutput("abort_no_rsp", 32'(rspCount - r0), 32'd0);
    portMoney[0] = 6'h1F; portMoney[3] = 6'h05;
    pushExp(0, 1'b0); pushExp(3, 1'b0);
    applyStimulus(4'b1001, 2);
    waitIdle("after_reset", 100);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
    $finish;
  end

endmodule
